control_sentido_contador: RTL and testbench



---
 rtl/control_sentido_contador_pkg.sv | 44 ++++
 rtl/control_sentido_contador_comparador_limites.sv | 32 +++
 rtl/control_sentido_contador.sv | 93 +++++++++
 tb/tb_control_sentido_contador.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/control_sentido_contador_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : control_sentido_contador_pkg
//  Description : Shared definitions for the up/down counter direction
//                controller: 3-bit FSM state codes, default turn limits and
//                small decode helpers for the registered outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
package control_sentido_contador_pkg;

    localparam int         c_ST_W      = 3;

    // FSM state codes (also visible on the ESTADO debug port)
    localparam logic [2:0] c_REPOSO    = 3'd0;
    localparam logic [2:0] c_SUBIENDO  = 3'd1;
    localparam logic [2:0] c_FRENO_S   = 3'd2;
    localparam logic [2:0] c_GIRO_S    = 3'd3;
    localparam logic [2:0] c_BAJANDO   = 3'd4;
    localparam logic [2:0] c_FRENO_B   = 3'd5;
    localparam logic [2:0] c_GIRO_B    = 3'd6;

    // Default turn points cover the full 4-bit range
    localparam logic [3:0] c_LIM_INF_DEF = 4'd0;
    localparam logic [3:0] c_LIM_SUP_DEF = 4'd15;

    // Direction requested from the counter in a given state (1 = down).
    // The flip happens in GIRO_x, while the counter is already frozen.
    function automatic logic f_decninc(input logic [2:0] st);
        logic r;
        r = 1'b0;
        case (st)
            c_GIRO_S, c_BAJANDO, c_FRENO_B: r = 1'b1;
            default:                        r = 1'b0;
        endcase
        return r;
    endfunction

    // States in which the counter is allowed to run
    function automatic logic f_en_marcha(input logic [2:0] st);
        return (st == c_SUBIENDO) || (st == c_BAJANDO);
    endfunction

endpackage : control_sentido_contador_pkg
`default_nettype wire

// File: rtl/control_sentido_contador_comparador_limites.sv
`default_nettype none
// ============================================================================
//  Module      : comparador_limites
//  Description : Combinational limit detector for the counter feedback.
//                o_en_sup = (i_o >= i_lim_sup), o_en_inf = (i_o <= i_lim_inf).
//                Inclusive compares catch values left outside the range,
//                since the counter itself has no reset.
//  Ports       : i_o       [3:0] counter value
//                i_lim_inf [3:0] lower turn point
//                i_lim_sup [3:0] upper turn point
//                o_en_sup        at or above upper limit
//                o_en_inf        at or below lower limit
//  Revision    : 1.0 - initial release
// ============================================================================
module comparador_limites (
    input  logic [3:0] i_o,
    input  logic [3:0] i_lim_inf,
    input  logic [3:0] i_lim_sup,
    output logic       o_en_sup,
    output logic       o_en_inf
);

    always_comb begin
        o_en_sup = (i_o >= i_lim_sup);
        o_en_inf = (i_o <= i_lim_inf);
        // Both flags at once would make the turn direction ambiguous
        assert (i_lim_inf < i_lim_sup)
            else $error("comparador_limites: LIM_INF must be below LIM_SUP");
    end

endmodule : comparador_limites
`default_nettype wire

// File: rtl/control_sentido_contador.sv
`default_nettype none
// ============================================================================
//  Module      : control_sentido_contador
//  Description : Direction controller for a 4-bit up/down ripple counter.
//                Bounces the count between LIM_INF and LIM_SUP. Every turn
//                is hold -> flip direction -> release so the direction
//                change never clocks the ripple chain spuriously.
//  Ports       : C        clock (counter advances on the falling edge)
//                CLR      synchronous active-high reset
//                START    leave REPOSO and count up
//                PAUSA    level, freezes the counter while running
//                O  [3:0] counter value (feedback)
//                DECnINC  0 = up, 1 = down (registered)
//                nHOLD    0 = counter frozen (registered)
//                ESTADO [2:0] FSM state code (debug)
//                VUELTAS [3:0] completed round trips, modulo 16
//  Revision    : 1.0 - initial release
// ============================================================================
module control_sentido_contador
    import control_sentido_contador_pkg::*;
#(
    parameter logic [3:0] LIM_INF = c_LIM_INF_DEF,
    parameter logic [3:0] LIM_SUP = c_LIM_SUP_DEF
) (
    input  logic       C,
    input  logic       CLR,
    input  logic       START,
    input  logic       PAUSA,
    input  logic [3:0] O,
    output logic       DECnINC,
    output logic       nHOLD,
    output logic [2:0] ESTADO,
    output logic [3:0] VUELTAS
);

    logic [c_ST_W-1:0] r_estado;
    logic [c_ST_W-1:0] w_estado_sig;
    logic              r_decninc;
    logic              r_nhold;
    logic [3:0]        r_vueltas;
    logic              w_en_sup;
    logic              w_en_inf;

    comparador_limites u_comparador (
        .i_o       (O),
        .i_lim_inf (LIM_INF),
        .i_lim_sup (LIM_SUP),
        .o_en_sup  (w_en_sup),
        .o_en_inf  (w_en_inf)
    );

    // Next state. PAUSA never appears here: it only gates nHOLD, so a limit
    // hit while paused still starts the turn.
    always_comb begin
        w_estado_sig = c_REPOSO;
        case (r_estado)
            c_REPOSO:   w_estado_sig = START    ? c_SUBIENDO : c_REPOSO;
            c_SUBIENDO: w_estado_sig = w_en_sup ? c_FRENO_S  : c_SUBIENDO;
            c_FRENO_S:  w_estado_sig = c_GIRO_S;
            c_GIRO_S:   w_estado_sig = c_BAJANDO;
            c_BAJANDO:  w_estado_sig = w_en_inf ? c_FRENO_B  : c_BAJANDO;
            c_FRENO_B:  w_estado_sig = c_GIRO_B;
            c_GIRO_B:   w_estado_sig = c_SUBIENDO;
            default:    w_estado_sig = c_REPOSO;
        endcase
    end

    // Outputs are registered from the next state so that the edge which
    // samples O at a limit also drops nHOLD, before the counter's falling
    // edge can step past the limit.
    always_ff @(posedge C) begin
        if (CLR) begin
            r_estado  <= c_REPOSO;
            r_decninc <= 1'b0;
            r_nhold   <= 1'b0;
            r_vueltas <= 4'd0;
        end else begin
            r_estado  <= w_estado_sig;
            r_decninc <= f_decninc(w_estado_sig);
            r_nhold   <= f_en_marcha(w_estado_sig) && !PAUSA;
            if (r_estado == c_GIRO_B) begin
                r_vueltas <= r_vueltas + 4'd1;
            end
        end
    end

    assign ESTADO  = r_estado;
    assign DECnINC = r_decninc;
    assign nHOLD   = r_nhold;
    assign VUELTAS = r_vueltas;

endmodule : control_sentido_contador
`default_nettype wire

// File: tb/tb_control_sentido_contador.sv
`default_nettype none
// ============================================================================
//  Module      : tb_control_sentido_contador
//  Description : Closed-loop bench: the controller drives a behavioural
//                4-bit up/down counter (falling-edge) whose value feeds back
//                on O. A direction/turn-phase model predicts every output.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_control_sentido_contador;

    localparam logic [3:0] c_LIM_INF = 4'd1;
    localparam logic [3:0] c_LIM_SUP = 4'd5;

    logic       C = 1'b0;
    logic       CLR = 1'b1;
    logic       START = 1'b0;
    logic       PAUSA = 1'b0;
    logic [3:0] O = 4'd0;
    logic       DECnINC;
    logic       nHOLD;
    logic [2:0] ESTADO;
    logic [3:0] VUELTAS;

    int n_tests = 0;
    int n_fail  = 0;

    control_sentido_contador #(
        .LIM_INF (c_LIM_INF),
        .LIM_SUP (c_LIM_SUP)
    ) dut (
        .C       (C),
        .CLR     (CLR),
        .START   (START),
        .PAUSA   (PAUSA),
        .O       (O),
        .DECnINC (DECnINC),
        .nHOLD   (nHOLD),
        .ESTADO  (ESTADO),
        .VUELTAS (VUELTAS)
    );

    always #5 C = ~C;

    // Counter plant: no reset, advances on the falling edge, optional load
    logic       load_en  = 1'b0;
    logic [3:0] load_val = 4'd0;
    always @(negedge C) begin
        if (load_en)      O <= load_val;
        else if (nHOLD)   O <= DECnINC ? O - 4'd1 : O + 4'd1;
    end

    // Reference model: running flag, travel direction, frozen cycles left
    // in the current turn (2 = braking, 1 = just flipped), lap count.
    bit         m_run  = 1'b0;
    bit         m_dir  = 1'b0;
    int         m_turn = 0;
    int         m_laps = 0;
    bit         m_hold = 1'b0;
    logic [3:0] m_o    = 4'd0;

    function automatic int exp_code();
        if (!m_run)      return 0;
        if (m_turn == 0) return m_dir ? 4 : 1;
        if (m_turn == 2) return m_dir ? 5 : 2;
        return m_dir ? 3 : 6;
    endfunction

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick(input bit clr, input bit start, input bit pausa);
        @(negedge C);
        #1;
        if (load_en) begin
            m_o     = load_val;
            load_en = 1'b0;
        end else if (m_hold) begin
            m_o = m_dir ? m_o - 4'd1 : m_o + 4'd1;
        end
        check_eq("O", int'(O), int'(m_o));
        CLR   = clr;
        START = start;
        PAUSA = pausa;
        if (clr) begin
            m_run = 0; m_dir = 0; m_turn = 0; m_laps = 0;
        end else if (!m_run) begin
            if (start) begin m_run = 1; m_dir = 0; end
        end else if (m_turn == 2) begin
            m_turn = 1; m_dir = ~m_dir;
        end else if (m_turn == 1) begin
            m_turn = 0;
            if (!m_dir) m_laps = (m_laps + 1) % 16;
        end else if (!m_dir ? (m_o >= c_LIM_SUP) : (m_o <= c_LIM_INF)) begin
            m_turn = 2;
        end
        m_hold = m_run && (m_turn == 0) && !pausa;
        @(posedge C);
        #1;
        check_eq("nHOLD",   int'(nHOLD),   int'(m_hold));
        check_eq("DECnINC", int'(DECnINC), int'(m_dir));
        check_eq("ESTADO",  int'(ESTADO),  exp_code());
        check_eq("VUELTAS", int'(VUELTAS), m_laps);
    endtask

    // Run until the model has just entered FRENO_S
    task automatic run_to_freno_s(input string tag);
        bit ok;
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            tick(0, 0, 0);
            ok = m_run && (m_turn == 2) && !m_dir;
        end
        check_eq(tag, int'(ok), 1);
    endtask

    initial begin
        bit ok;
        // Reset, then start
        tick(1, 0, 0);
        tick(1, 0, 0);
        tick(0, 1, 0);

        // Pause for four cycles with O held at 3 while counting up
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (m_run && m_turn == 0 && !m_dir && m_hold && m_o == 4'd2) ok = 1;
            else tick(0, 0, 0);
        end
        check_eq("reach_o3", int'(ok), 1);
        for (int i = 0; i < 4; i++) tick(0, 0, 1);
        check_eq("paused_at_3", int'(O), 3);
        tick(0, 0, 0);
        tick(0, 0, 0);

        // PAUSA raised during GIRO_S: turn still completes on schedule
        run_to_freno_s("reach_freno_s_a");
        tick(0, 0, 1);
        tick(0, 0, 1);
        tick(0, 0, 0);

        // Many round trips, VUELTAS wraps through 0
        for (int i = 0; i < 260; i++) tick(0, 0, 0);

        // Reset in the middle of a turn, then clean restart
        run_to_freno_s("reach_freno_s_b");
        tick(0, 0, 0);
        tick(1, 0, 0);
        tick(0, 1, 0);
        for (int i = 0; i < 12; i++) tick(0, 0, 0);

        // Counter left out of range at 9: turn at once, descend from 9
        tick(1, 0, 0);
        load_val = 4'd9;
        load_en  = 1'b1;
        tick(1, 0, 0);
        tick(0, 1, 1);
        tick(0, 0, 0);
        check_eq("oor_freno_s", int'(ESTADO), 2);
        for (int i = 0; i < 20; i++) tick(0, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            if (!m_run && $urandom_range(0, 7) == 0) begin
                load_val = 4'($urandom_range(0, 15));
                load_en  = 1'b1;
            end
            tick($urandom_range(0, 99) == 0,
                 $urandom_range(0, 5) == 0,
                 $urandom_range(0, 4) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule : tb_control_sentido_contador
`default_nettype wire
